// File: rtl/refresh_tick_gen.sv
// refresh_tick_gen: run-time programmable refresh divider producing tick, toggle clock, digit select and anode enables
module refresh_tick_gen #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 25000,
  parameter int NUM_DIGITS  = 4,
  parameter int SEL_W       = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  div_load,
  input  logic [CNT_W-1:0]      div_value,
  output logic                  tick,
  output logic                  clk_out,
  output logic [SEL_W-1:0]      digit_sel,
  output logic [NUM_DIGITS-1:0] anode_n,
  output logic                  frame_start,
  output logic [CNT_W-1:0]      div_active
);
  logic [CNT_W-1:0] count, pend_val, div_clamp;
  logic pend_vld, terminal;
  logic [SEL_W-1:0] sel_next;
  logic [NUM_DIGITS-1:0] one_hot;
  always_comb begin
    div_clamp = (div_value == '0) ? CNT_W'(1) : div_value;
    terminal  = enable && (count == div_active);
    sel_next  = !terminal ? digit_sel :
                (digit_sel == SEL_W'(NUM_DIGITS - 1)) ? '0 : digit_sel + 1'b1;
    one_hot   = NUM_DIGITS'(1) << sel_next;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count       <= '0;
      pend_val    <= '0;
      pend_vld    <= 1'b0;
      div_active  <= CNT_W'(DEFAULT_DIV);
      tick        <= 1'b0;
      frame_start <= 1'b0;
      clk_out     <= 1'b0;
      digit_sel   <= '0;
      anode_n     <= '1;
    end else begin
      tick        <= terminal;
      frame_start <= terminal && (sel_next == '0);
      clk_out     <= clk_out ^ terminal;
      digit_sel   <= sel_next;
      anode_n     <= enable ? ~one_hot : '1;
      if (!enable) begin
        if (div_load) begin
          div_active <= div_clamp;
          count      <= '0;
          pend_vld   <= 1'b0;
        end
      end else if (terminal) begin
        // a load arriving on the terminal edge beats any older pending value
        count      <= '0;
        div_active <= div_load ? div_clamp : pend_vld ? pend_val : div_active;
        pend_vld   <= 1'b0;
      end else begin
        count <= count + 1'b1;
        if (div_load) begin
          pend_val <= div_clamp;
          pend_vld <= 1'b1;
        end
      end
    end
  end
endmodule
